// File: rtl/gpu_cmd_pkg.sv
// ---------------------------------------------------------------------------
// gpu_cmd_pkg
// Shared definitions for the GPU input command stream: opcode values, field
// widths of a command word and the state encoding of the host-side encoder.
// No ports; imported by command_encoder.
// ---------------------------------------------------------------------------
package gpu_cmd_pkg;

  localparam int OPCODE_W = 4;
  localparam int TEX_W    = 8;
  localparam int COORD_W  = 16;
  localparam int WORD_W   = 32;

  // Opcode 0 is reserved so that an all-zero word never decodes as a command.
  localparam logic [OPCODE_W-1:0] OPC_RESERVED  = 4'd0;
  localparam logic [OPCODE_W-1:0] OPC_TRIANGLE  = 4'd1;
  localparam logic [OPCODE_W-1:0] OPC_FRAME_END = 4'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_V1,
    ST_V2,
    ST_V3,
    ST_FEND
  } enc_state_t;

  // Every state except IDLE drives a word towards the FIFO.
  function automatic logic isEmitState(input enc_state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/command_encoder.sv
// ---------------------------------------------------------------------------
// command_encoder
// Serializes triangle and frame-end requests into the 32-bit command word
// stream read by InputDecoder, honouring FIFO back-pressure and keeping
// per-frame statistics.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   tri_valid / tri_ready triangle request handshake
//   tex_num, x1..y3       triangle payload, captured on acceptance
//   frame_req / frame_ack frame-end request level and one-cycle acknowledge
//   fifo_full             downstream back-pressure
//   fifo_write, fifo_w_data  word strobe and data towards the FIFO
//   tri_count             triangles emitted in the current frame (saturating)
//   frame_count           frame-end markers emitted since reset (wrapping)
//   busy                  high whenever a packet is in flight
// ---------------------------------------------------------------------------
module command_encoder
  import gpu_cmd_pkg::*;
#(
  parameter logic [OPCODE_W-1:0] OP_TRIANGLE  = OPC_TRIANGLE,
  parameter logic [OPCODE_W-1:0] OP_FRAME_END = OPC_FRAME_END
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  logic [TEX_W-1:0]   tex_num,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  input  logic [COORD_W-1:0] x3,
  input  logic [COORD_W-1:0] y3,
  input  logic               frame_req,
  output logic               frame_ack,
  input  logic               fifo_full,
  output logic               fifo_write,
  output logic [WORD_W-1:0]  fifo_w_data,
  output logic [15:0]        tri_count,
  output logic [15:0]        frame_count,
  output logic               busy
);

  enc_state_t state_q, state_d;

  logic [TEX_W-1:0]   texNum_q;
  logic [COORD_W-1:0] x1_q, y1_q, x2_q, y2_q, x3_q, y3_q;
  logic [15:0]        triCount_q, triCount_d;
  logic [15:0]        frameCount_q, frameCount_d;
  logic               frameAck_q;
  logic               triAccept;

  // A pending frame request blocks new triangles so the marker is not
  // overtaken; a triangle already captured still finishes first because
  // FEND is only reachable from IDLE.
  assign tri_ready = (state_q == ST_IDLE) && !frame_req;
  assign triAccept = tri_valid && tri_ready;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: emit states only advance on an edge where the word is
  // actually written, so a full FIFO just stretches the current word.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_req) begin
          state_d = ST_FEND;
        end else if (tri_valid) begin
          state_d = ST_HDR;
        end
      end
      ST_HDR:  if (fifo_write) state_d = ST_V1;
      ST_V1:   if (fifo_write) state_d = ST_V2;
      ST_V2:   if (fifo_write) state_d = ST_V3;
      ST_V3:   if (fifo_write) state_d = ST_IDLE;
      ST_FEND: if (fifo_write) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: word selection and write strobe for the current state.
  always_comb begin
    fifo_w_data = '0;
    unique case (state_q)
      ST_HDR:  fifo_w_data = {OP_TRIANGLE, 20'd0, texNum_q};
      ST_V1:   fifo_w_data = {x1_q, y1_q};
      ST_V2:   fifo_w_data = {x2_q, y2_q};
      ST_V3:   fifo_w_data = {x3_q, y3_q};
      ST_FEND: fifo_w_data = {OP_FRAME_END, 28'd0};
      default: fifo_w_data = '0;
    endcase
    fifo_write = isEmitState(state_q) && !fifo_full;
    busy       = (state_q != ST_IDLE);
  end

  // Statistics: the frame-end write both counts the frame and opens a new
  // one, so it clears the per-frame triangle count on the same edge.
  always_comb begin
    triCount_d   = triCount_q;
    frameCount_d = frameCount_q;
    if (fifo_write && (state_q == ST_V3) && (triCount_q != 16'hFFFF)) begin
      triCount_d = triCount_q + 16'd1;
    end
    if (fifo_write && (state_q == ST_FEND)) begin
      triCount_d   = 16'd0;
      frameCount_d = frameCount_q + 16'd1;
    end
  end

  // Holding registers and counters; the payload is latched at acceptance so
  // the requester is free to change its inputs straight away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      texNum_q     <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      x2_q         <= '0;
      y2_q         <= '0;
      x3_q         <= '0;
      y3_q         <= '0;
      triCount_q   <= '0;
      frameCount_q <= '0;
      frameAck_q   <= 1'b0;
    end else begin
      if (triAccept) begin
        texNum_q <= tex_num;
        x1_q     <= x1;
        y1_q     <= y1;
        x2_q     <= x2;
        y2_q     <= y2;
        x3_q     <= x3;
        y3_q     <= y3;
      end
      triCount_q   <= triCount_d;
      frameCount_q <= frameCount_d;
      frameAck_q   <= fifo_write && (state_q == ST_FEND);
    end
  end

  assign frame_ack   = frameAck_q;
  assign tri_count   = triCount_q;
  assign frame_count = frameCount_q;

endmodule

// File: doc/command_encoder.md
# command_encoder

Host-side transmitter for the GPU input command stream: it accepts whole triangle requests and end-of-frame requests and serializes them into the 32-bit word stream (`fifo_write`/`fifo_w_data`) consumed by InputDecoder. It sits between the host/bus interface and the input FIFO. It honours FIFO back-pressure, orders frame markers behind any in-flight triangle, and keeps per-frame statistics.

## Interface
- `OP_TRIANGLE`, default 4'd1: opcode placed in header bits [31:28] of a triangle packet.
- `OP_FRAME_END`, default 4'd2: opcode of the single-word frame-end packet.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `tri_valid` in 1: a triangle request is present on `tex_num`, `x1`…`y3`.
- `tri_ready` out 1: the block can accept a triangle this cycle.
- `tex_num` in 8: texture number for the triangle.
- `x1`, `y1`, `x2`, `y2`, `x3`, `y3` in 16 each: vertex coordinates.
- `frame_req` in 1: request to emit a frame-end marker; a level that is held until acknowledged.
- `frame_ack` out 1: one-cycle pulse on the edge at which the frame-end word is written.
- `fifo_full` in 1: downstream FIFO cannot take a word this cycle.
- `fifo_write` out 1: write strobe.
- `fifo_w_data` out 32: word being written.
- `tri_count` out 16: triangles emitted in the current frame.
- `frame_count` out 16: frame-end markers emitted since reset.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: waiting for a request.
  - HDR, V1, V2, V3: emitting the four words of a triangle.
  - FEND: emitting the frame-end word.
- Triangle packet, 4 words in this order:
  - header {OP_TRIANGLE, 20'd0, tex_num}
  - {x1, y1}
  - {x2, y2}
  - {x3, y3}
- Frame-end packet, 1 word: {OP_FRAME_END, 28'd0}.
- `tri_ready` = (state == IDLE) && !frame_req. A pending frame request blocks new triangles.
- When `tri_valid && tri_ready` at an edge, all inputs are captured into holding registers and the state moves IDLE→HDR. The requester may change its inputs immediately afterwards.
- In IDLE with `frame_req` high, the state moves to FEND.
  - Because `tri_ready` is low while `frame_req` is high, a simultaneous triangle is not accepted. The frame end goes first and the triangle is taken on a later cycle.
  - A triangle already captured always completes before FEND is entered.
- Emit states, combinational outputs:
  - `fifo_write` = emit state && !fifo_full.
  - `fifo_w_data` = the word for the current state.
  - In IDLE, `fifo_w_data` = 32'd0.
- Advance: HDR→V1→V2→V3→IDLE and FEND→IDLE, on an edge with `fifo_write` high only. While `fifo_full` is high the state holds and no word is lost or duplicated.
- `tri_count` increments on the V3 write edge.
- On the FEND write edge:
  - `frame_count` increments, wrapping 16'hFFFF→0.
  - `tri_count` clears to 0, because that edge also opens a new frame.
  - `frame_ack` pulses.
- `tri_count` saturates at 16'hFFFF.

## Timing
- Reset values:
  - state = IDLE
  - `tri_ready` = 1 (when `frame_req` = 0)
  - `fifo_write` = 0
  - `fifo_w_data` = 0
  - `frame_ack` = 0
  - `tri_count` = 0
  - `frame_count` = 0
  - `busy` = 0
- Triangle accepted at edge k with no stall: words are written at edges k+1, k+2, k+3 and k+4, and `tri_ready` is high again after edge k+4. The next triangle can be accepted at edge k+5, giving a peak rate of 1 triangle per 5 cycles.
- Each cycle of `fifo_full` adds one cycle of latency to the word currently being emitted.
- Frame request seen in IDLE at edge k: the word is written at edge k+1 (if not full), and `frame_ack` is high in the cycle following that edge.
- Reset asserted mid-packet: the partial packet is abandoned, the holding registers are cleared, and nothing further is emitted.

## Structure
- Shared package `gpu_cmd_pkg` holds:
  - the opcode constants (triangle = 1, frame-end = 2; opcode 0 reserved)
  - the state enum `enc_state_t`
  - the word-field widths (opcode 4, tex 8, coordinate 16)
- No sub-module is needed; the block is a single FSM with its holding registers and two counters.

## Test plan
- Triangle with tex_num=2 and vertices 3,4,5,6,7,8, `fifo_full`=0 → writes 0x10000002, 0x00030004, 0x00050006 and 0x00070008 on 4 consecutive edges; then `tri_count`=1.
- `frame_req` held in IDLE → one write of 0x20000000, a `frame_ack` pulse, `frame_count`=1 and `tri_count`=0.
- The same triangle with `fifo_full` high for 3 cycles during V1 → the identical 4-word sequence, still exactly 4 writes, finishing 3 cycles later.
- `tri_valid` and `frame_req` rising in the same IDLE cycle → 0x20000000 first, then the 4 triangle words; `tri_count` ends at 1.
- Frame request raised during V2 of a triangle (tex 100; vertices 500,666,777,345,845,984) → the triangle completes (last word 0x034D03D8), then 0x20000000 immediately follows.
- `reset` pulled low after the header write → `fifo_write` is 0 immediately, all counters are 0, and no V1 word appears after release.
